// File: rtl/vga_output_stage.sv
// vga_output_stage: final pixel stage ahead of the uo_out pins.
// Reduces 3-bit channels to 2 bits with an ordered dither whose phase comes
// only from sync edges, can substitute a colour-bar pattern switched at frame
// boundaries, blanks outside active video and keeps syncs aligned with colour.
module vga_output_stage #(
    parameter bit TEMPORAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rin,
    input  logic [2:0] gin,
    input  logic [2:0] bin,
    input  logic       visible,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       test_en,
    output logic [7:0] uo_out
);

    // Previous sync levels for fall detection
    logic       hsPrev_q;
    logic       vsPrev_q;

    // Screen position and frame state
    logic       xpar_q, xpar_d;
    logic       ypar_q, ypar_d;
    logic       fpar_q, fpar_d;
    logic [9:0] xcnt_q, xcnt_d;
    logic       tpActive_q, tpActive_d;

    // Stage 1: selected colour, dither bit, visibility and syncs
    logic [2:0] s1Red_q, s1Green_q, s1Blue_q;
    logic       s1Dith_q;
    logic       s1Vis_q;
    logic       s1Hs_q;
    logic       s1Vs_q;

    // Stage 2: output register
    logic [7:0] uo_q, uo_d;

    logic       hsFall;
    logic       vsFall;
    logic       dithBit;
    logic [2:0] bar;
    logic [2:0] selRed, selGreen, selBlue;
    logic [1:0] outRed, outGreen, outBlue;

    assign hsFall  = hsPrev_q & ~hsync;
    assign vsFall  = vsPrev_q & ~vsync;
    assign dithBit = xpar_q ^ ypar_q ^ (TEMPORAL & fpar_q);
    assign bar     = xcnt_q[9:7];

    // Round the top two bits up when the dropped LSB is set on a dither-on pixel, stopping at 3
    function automatic logic [1:0] ditherChan(input logic [2:0] c, input logic d);
        logic [1:0] res;
        res = c[2:1];
        if (c[0] && d && (c[2:1] != 2'b11)) begin
            res = c[2:1] + 2'd1;
        end
        return res;
    endfunction

    // Next position/frame state; a clearing edge always beats a toggle or count
    always_comb begin
        xpar_d     = xpar_q;
        ypar_d     = ypar_q;
        fpar_d     = fpar_q;
        xcnt_d     = xcnt_q;
        tpActive_d = tpActive_q;
        if (hsFall) begin
            xpar_d = 1'b0;
            xcnt_d = 10'd0;
        end else if (visible) begin
            xpar_d = ~xpar_q;
            if (xcnt_q != 10'd1023) begin
                xcnt_d = xcnt_q + 10'd1;
            end
        end
        if (vsFall) begin
            ypar_d     = 1'b0;
            fpar_d     = ~fpar_q;
            tpActive_d = test_en;
        end else if (hsFall) begin
            ypar_d = ~ypar_q;
        end
    end

    // Colour source: bars from the pixel counter, or the compositor pass-through
    always_comb begin
        selRed   = rin;
        selGreen = gin;
        selBlue  = bin;
        if (tpActive_q) begin
            selRed   = {3{bar[2]}};
            selGreen = {3{bar[1]}};
            selBlue  = {3{bar[0]}};
        end
    end

    // Dither and blank the stage-1 pixel, then pack it with the delayed syncs
    always_comb begin
        outRed   = 2'b00;
        outGreen = 2'b00;
        outBlue  = 2'b00;
        if (s1Vis_q) begin
            outRed   = ditherChan(s1Red_q, s1Dith_q);
            outGreen = ditherChan(s1Green_q, s1Dith_q);
            outBlue  = ditherChan(s1Blue_q, s1Dith_q);
        end
        uo_d = {s1Hs_q, outBlue[0], outGreen[0], outRed[0],
                s1Vs_q, outBlue[1], outGreen[1], outRed[1]};
    end

    // Edge-detect registers and position state, idle on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsPrev_q   <= 1'b1;
            vsPrev_q   <= 1'b1;
            xpar_q     <= 1'b0;
            ypar_q     <= 1'b0;
            fpar_q     <= 1'b0;
            xcnt_q     <= 10'd0;
            tpActive_q <= 1'b0;
        end else begin
            hsPrev_q   <= hsync;
            vsPrev_q   <= vsync;
            xpar_q     <= xpar_d;
            ypar_q     <= ypar_d;
            fpar_q     <= fpar_d;
            xcnt_q     <= xcnt_d;
            tpActive_q <= tpActive_d;
        end
    end

    // Two-stage pixel pipeline; reset flushes both stages to blank with syncs high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Red_q   <= 3'd0;
            s1Green_q <= 3'd0;
            s1Blue_q  <= 3'd0;
            s1Dith_q  <= 1'b0;
            s1Vis_q   <= 1'b0;
            s1Hs_q    <= 1'b1;
            s1Vs_q    <= 1'b1;
            uo_q      <= 8'h88;
        end else begin
            s1Red_q   <= selRed;
            s1Green_q <= selGreen;
            s1Blue_q  <= selBlue;
            s1Dith_q  <= dithBit;
            s1Vis_q   <= visible;
            s1Hs_q    <= hsync;
            s1Vs_q    <= vsync;
            uo_q      <= uo_d;
        end
    end

    assign uo_out = uo_q;

endmodule

// File: tb/tb_vga_output_stage.sv
// tb_vga_output_stage: directed scoreboard bench. Each driven pixel pushes its
// hand-derived expected output; the entry is popped and compared once the
// pixel has crossed both pipeline stages. A TEMPORAL=1 and a TEMPORAL=0
// instance share the stimulus.
module tb_vga_output_stage;

    typedef struct {
        logic [7:0] expT;
        bit         chkT;
        logic [7:0] expS;
        bit         chkS;
        string      tag;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rin, gin, bin;
    logic       visible, hsync, vsync, test_en;
    logic [7:0] uoT, uoS;
    logic       tenVal;

    entry_t     sb[$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    vga_output_stage #(.TEMPORAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rin(rin), .gin(gin), .bin(bin),
        .visible(visible), .hsync(hsync), .vsync(vsync), .test_en(test_en),
        .uo_out(uoT)
    );

    vga_output_stage #(.TEMPORAL(1'b0)) dutStatic (
        .clk(clk), .rst_n(rst_n), .rin(rin), .gin(gin), .bin(bin),
        .visible(visible), .hsync(hsync), .vsync(vsync), .test_en(test_en),
        .uo_out(uoS)
    );

    // Dither output for colour 3'b011: F8 when the dither bit is 0, 8F when 1
    function automatic logic [7:0] alt(input int i, input bit ph);
        return ((i % 2 == 1) ^ ph) ? 8'h8F : 8'hF8;
    endfunction

    // Colour-bar output for the k-th visible pixel of a line (counter saturates at 1023)
    function automatic logic [7:0] barExp(input int k);
        int         x;
        logic [2:0] b;
        logic [7:0] e;
        x = (k > 1023) ? 1023 : k;
        b = 3'(x / 128);
        e = 8'h88;
        if (b[2]) e = e | 8'h11;
        if (b[1]) e = e | 8'h22;
        if (b[0]) e = e | 8'h44;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] c, input logic vis,
                                 input logic hs, input logic vs,
                                 input logic [7:0] eT, input bit cT,
                                 input logic [7:0] eS, input bit cS, input string tag);
        entry_t ent;
        @(negedge clk);
        rst_n   = rst;
        rin     = c;
        gin     = c;
        bin     = c;
        visible = vis;
        hsync   = hs;
        vsync   = vs;
        test_en = tenVal;
        ent.expT = eT;
        ent.chkT = cT;
        ent.expS = eS;
        ent.chkS = cS;
        ent.tag  = tag;
        sb.push_back(ent);
        @(posedge clk);
        #1;
        if (!rst) begin
            while (sb.size() > 1) void'(sb.pop_front());
            checkOutput({tag, "_hold"}, uoT, 8'h88);
            checkOutput({tag, "_hold_static"}, uoS, 8'h88);
        end else if (sb.size() >= 2) begin
            ent = sb.pop_front();
            if (ent.chkT) checkOutput(ent.tag, uoT, ent.expT);
            if (ent.chkS) checkOutput({ent.tag, "_static"}, uoS, ent.expS);
        end
    endtask

    task automatic px(input logic [2:0] c, input logic vis, input logic hs, input logic vs,
                      input logic [7:0] eT, input bit cS, input logic [7:0] eS, input string tag);
        applyStimulus(1'b1, c, vis, hs, vs, eT, 1'b1, eS, cS, tag);
    endtask

    task automatic ditherRow(input int n, input bit phT, input bit cS, input bit phS, input string tag);
        for (int i = 0; i < n; i++) begin
            px(3'b011, 1'b1, 1'b1, 1'b1, alt(i, phT), cS, alt(i, phS), tag);
        end
    endtask

    initial begin
        tenVal = 1'b0;

        // Reset held with colour, visible and syncs low
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 8'h88, 1'b1, 8'h88, 1'b1, "reset");
        end

        // Frame 0 row 0 starts with dither off; row 1 after an hsync fall inverts
        ditherRow(8, 1'b0, 1'b1, 1'b0, "dither_row0");
        px(3'b011, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 8'h08, "hsync_fall");
        ditherRow(8, 1'b1, 1'b1, 1'b1, "dither_row1");

        // vsync fall: row parity clears, frame parity toggles only for the temporal instance
        px(3'b011, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 8'h80, "vsync_fall");
        ditherRow(8, 1'b1, 1'b1, 1'b0, "dither_frame1");

        // Saturation and blanking
        for (int i = 0; i < 4; i++) px(3'b111, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, "saturate");
        for (int i = 0; i < 2; i++) px(3'b111, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 8'h88, "blank");
        px(3'b111, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 8'h08, "blank_hsync");

        // test_en raised mid-frame has no effect until the next vsync fall
        tenVal = 1'b1;
        ditherRow(4, 1'b0, 1'b1, 1'b1, "tp_pending");
        px(3'b011, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 8'h80, "tp_vsync");
        px(3'b011, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 8'h08, "tp_hsync");
        for (int k = 0; k < 640; k++) begin
            px(3'b011, 1'b1, 1'b1, 1'b1, barExp(k), 1'b1, barExp(k), $sformatf("bar_px%0d", k));
        end
        for (int i = 0; i < 4; i++) px(3'b011, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 8'h88, "bar_blank");

        // Long line to reach the counter ceiling
        px(3'b011, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 8'h08, "long_hsync");
        for (int k = 0; k < 1100; k++) begin
            px(3'b011, 1'b1, 1'b1, 1'b1, barExp(k), 1'b1, barExp(k), $sformatf("long_px%0d", k));
        end
        for (int i = 0; i < 2; i++) px(3'b011, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 8'h88, "long_blank");

        // Pattern off again at a vsync fall
        tenVal = 1'b0;
        px(3'b011, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 8'h80, "tp_off_vsync");
        px(3'b011, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 8'h88, "idle");

        // Two frames starting with simultaneous hsync/vsync falls
        for (int f = 0; f < 2; f++) begin
            px(3'b011, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, "both_fall");
            ditherRow(6, (f == 1), 1'b1, 1'b0, $sformatf("frame%0d_row0", f));
            px(3'b011, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 8'h08, "frame_hsync");
            ditherRow(6, (f == 0), 1'b1, 1'b1, $sformatf("frame%0d_row1", f));
            px(3'b011, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 8'h88, "frame_idle");
        end

        // Reset in the middle of visible pixels must not leak anything already in flight
        for (int i = 0; i < 3; i++) px(3'b111, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, "pre_reset");
        applyStimulus(1'b0, 3'b111, 1'b1, 1'b1, 1'b1, 8'h88, 1'b1, 8'h88, 1'b1, "midline_reset");
        for (int i = 0; i < 3; i++) px(3'b111, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, "post_reset");

        // Drain the pipeline
        for (int i = 0; i < 2; i++) px(3'b000, 1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 8'h88, "drain");
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 8'h88, 1'b0, 8'h88, 1'b0, "tail");
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 8'h88, 1'b0, 8'h88, 1'b0, "tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
